// File: rtl/alu_sequencer.sv
// Two-state command sequencer feeding a combinational 64-bit ALU from a register bank.
// Define ALU_SEQUENCER_OVF_EN to compile signed-overflow reporting on add/sub.
module alu_sequencer #(
  parameter int WORDSIZE = 64,
  parameter int NREGS    = 8,
  parameter int RAW      = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4:0]          cmd_op,
  input  logic [RAW-1:0]      cmd_dst,
  input  logic [RAW-1:0]      cmd_src_a,
  input  logic [RAW-1:0]      cmd_src_b,
  input  logic                cmd_imm_en,
  input  logic [WORDSIZE-1:0] cmd_imm,
  output logic [WORDSIZE-1:0] alu_a,
  output logic [WORDSIZE-1:0] alu_b,
  output logic [4:0]          alu_op,
  input  logic [WORDSIZE-1:0] alu_result,
  output logic                done,
  output logic [RAW-1:0]      done_dst,
  output logic [WORDSIZE-1:0] done_data,
  output logic                ovf,
  input  logic [RAW-1:0]      rd_addr,
  output logic [WORDSIZE-1:0] rd_data
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state;
  logic [WORDSIZE-1:0] bank [NREGS];
  logic [RAW-1:0]      dst_q;
  logic [WORDSIZE-1:0] opnd_a;
  logic [WORDSIZE-1:0] opnd_b;
  logic                ovf_next;

  // r0 is forced to zero on every read path
  assign opnd_a  = (cmd_src_a == '0) ? '0 : bank[cmd_src_a];
  assign opnd_b  = cmd_imm_en ? cmd_imm :
                   (cmd_src_b == '0) ? '0 : bank[cmd_src_b];
  assign rd_data = (rd_addr == '0) ? '0 : bank[rd_addr];

`ifdef ALU_SEQUENCER_OVF_EN
  logic sa, sb, sr;
  assign sa = alu_a[WORDSIZE-1];
  assign sb = alu_b[WORDSIZE-1];
  assign sr = alu_result[WORDSIZE-1];

  always_comb begin
    ovf_next = 1'b0;
    unique case (alu_op)
      5'd2:    ovf_next = (sa == sb) && (sr != sa);
      5'd3:    ovf_next = (sa != sb) && (sr != sa);
      default: ovf_next = 1'b0;
    endcase
  end
`else
  assign ovf_next = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      dst_q     <= '0;
      done      <= 1'b0;
      done_dst  <= '0;
      done_data <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a     <= opnd_a;
            alu_b     <= opnd_b;
            alu_op    <= cmd_op;
            dst_q     <= cmd_dst;
            cmd_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (dst_q != '0) bank[dst_q] <= alu_result;
          done      <= 1'b1;
          done_dst  <= dst_q;
          done_data <= alu_result;
          ovf       <= ovf_next;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, reset/handshake corner cases,
// and random commands against an arithmetic register-bank model.
module tb_alu_sequencer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_dst;
  logic [2:0]  cmd_src_a;
  logic [2:0]  cmd_src_b;
  logic        cmd_imm_en;
  logic [63:0] cmd_imm;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_result;
  logic        done;
  logic [2:0]  done_dst;
  logic [63:0] done_data;
  logic        ovf;
  logic [2:0]  rd_addr;
  logic [63:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl_bank [8];

  alu_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .done(done), .done_dst(done_dst), .done_data(done_data),
    .ovf(ovf), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // External combinational ALU
  always_comb begin
    alu_result = 64'd0;
    case (alu_op)
      5'd0: alu_result = alu_a;
      5'd1: alu_result = alu_b;
      5'd2: alu_result = alu_a + alu_b;
      5'd3: alu_result = alu_a - alu_b;
      default: alu_result = 64'd0;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mdl_res(input logic [4:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    if (op == 5'd0) return a;
    if (op == 5'd1) return b;
    if (op == 5'd2) return a + b;
    if (op == 5'd3) return a - b;
    return 64'd0;
  endfunction

  // Overflow = the exact 65-bit signed result does not fit in 64 bits
  function automatic logic mdl_ovf(input logic [4:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    logic [64:0] r;
`ifdef ALU_SEQUENCER_OVF_EN
    if (op == 5'd2) r = {a[63], a} + {b[63], b};
    else if (op == 5'd3) r = {a[63], a} - {b[63], b};
    else return 1'b0;
    return r[64] != r[63];
`else
    r = {a[63], a} ^ {b[63], b} ^ {60'd0, op};
    return 1'b0 & r[0];
`endif
  endfunction

  task automatic run_cmd(input logic [4:0] op, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb,
                         input logic ie, input logic [63:0] imm,
                         input logic [63:0] exp, input logic exp_ovf);
    logic [63:0] a, b;
    a = (sa == 3'd0) ? 64'd0 : mdl_bank[sa];
    b = ie ? imm : ((sb == 3'd0) ? 64'd0 : mdl_bank[sb]);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
    cmd_src_a = sa; cmd_src_b = sb; cmd_imm_en = ie; cmd_imm = imm;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("issue_ready", {63'd0, cmd_ready}, 64'd0);
    chk("issue_done", {63'd0, done}, 64'd0);
    chk("issue_alu_a", alu_a, a);
    chk("issue_alu_b", alu_b, b);
    chk("issue_alu_op", {59'd0, alu_op}, {59'd0, op});
    @(posedge clock); #1;
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("done_dst", {61'd0, done_dst}, {61'd0, dst});
    chk("done_data", done_data, exp);
    chk("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
    if (dst != 3'd0) mdl_bank[dst] = exp;
    rd_addr = dst; #1;
    chk("writeback", rd_data, (dst == 3'd0) ? 64'd0 : mdl_bank[dst]);
    @(posedge clock); #1;
    chk("done_low", {63'd0, done}, 64'd0);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  dst;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic        ie;
    logic [63:0] imm;
    logic [63:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [4:0] op;
    logic [63:0] imm, a, b, e;
    logic [2:0] dst, sa, sb;
    logic ie, eo;
    int ndone;

    vecs[0] = '{5'd1, 3'd1, 3'd0, 3'd0, 1'b1, 64'd5, 64'd5, 1'b0};
    vecs[1] = '{5'd1, 3'd2, 3'd0, 3'd0, 1'b1, 64'd7, 64'd7, 1'b0};
    vecs[2] = '{5'd2, 3'd3, 3'd1, 3'd2, 1'b0, 64'd0, 64'd12, 1'b0};
    vecs[3] = '{5'd3, 3'd4, 3'd1, 3'd2, 1'b0, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[4] = '{5'd2, 3'd0, 3'd0, 3'd0, 1'b1, 64'd9, 64'd9, 1'b0};
    vecs[5] = '{5'd7, 3'd5, 3'd1, 3'd2, 1'b0, 64'd0, 64'd0, 1'b0};
    vecs[6] = '{5'd1, 3'd1, 3'd0, 3'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[7] = '{5'd2, 3'd7, 3'd1, 3'd0, 1'b1, 64'd1,
                64'h8000_0000_0000_0000, 1'b1};
    vecs[8] = '{5'd3, 3'd6, 3'd7, 3'd0, 1'b1, 64'd1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
    rd_addr = '0;
    for (int i = 0; i < 8; i++) mdl_bank[i] = 64'd0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", {59'd0, alu_op}, 64'd0);
    chk("rst_done_data", done_data, 64'd0);
    chk("rst_done_dst", {61'd0, done_dst}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); #1;
      chk("rst_bank", rd_data, 64'd0);
    end

    for (int i = 0; i < 9; i++) begin
`ifdef ALU_SEQUENCER_OVF_EN
      eo = vecs[i].ovf;
`else
      eo = 1'b0;
`endif
      run_cmd(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb,
              vecs[i].ie, vecs[i].imm, vecs[i].exp, eo);
    end

    for (int n = 0; n < 60; n++) begin
      op  = ($urandom_range(0, 9) < 9) ? 5'($urandom_range(0, 3))
                                       : 5'($urandom_range(4, 31));
      dst = 3'($urandom_range(0, 7));
      sa  = 3'($urandom_range(0, 7));
      sb  = 3'($urandom_range(0, 7));
      ie  = 1'($urandom_range(0, 1));
      imm = {$urandom(), $urandom()};
      a = (sa == 3'd0) ? 64'd0 : mdl_bank[sa];
      b = ie ? imm : ((sb == 3'd0) ? 64'd0 : mdl_bank[sb]);
      e  = mdl_res(op, a, b);
      eo = mdl_ovf(op, a, b);
      run_cmd(op, dst, sa, sb, ie, imm, e, eo);
    end

    // Reset while a command is in the ISSUE cycle
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 5'd2; cmd_dst = 3'd6;
    cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_imm_en = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("mid_accept", {63'd0, cmd_ready}, 64'd0);
    reset = 1'b1; #1;
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("mid_rst_alu_a", alu_a, 64'd0);
    @(posedge clock); #1;
    chk("mid_rst_done2", {63'd0, done}, 64'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_post_done", {63'd0, done}, 64'd0);
    chk("mid_post_ready", {63'd0, cmd_ready}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      mdl_bank[i] = 64'd0;
      rd_addr = 3'(i); #1;
      chk("mid_bank_clear", rd_data, 64'd0);
    end

    // cmd_valid held high: one accept every two cycles
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 5'd1; cmd_dst = 3'd1;
    cmd_src_a = 3'd0; cmd_imm_en = 1'b1; cmd_imm = 64'd3;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (done) ndone++;
      if (c % 2 == 0) chk("hold_ready_low", {63'd0, cmd_ready}, 64'd0);
    end
    @(negedge clock); cmd_valid = 1'b0;
    chk("hold_done_count", 64'(ndone), 64'd4);
    repeat (3) @(posedge clock); #1;
    chk("hold_idle_done", {63'd0, done}, 64'd0);
    rd_addr = 3'd1; #1;
    chk("hold_r1", rd_data, 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
